// File: rtl/histogram_esitleme_birimi.sv
// Histogram and histogram-equalisation unit. It counts a frame into register bins, then either
// dumps the bins or builds a CDF-normalised lookup and remaps a second frame through it.
module histogram_esitleme_birimi #(
  parameter int unsigned PIXEL_BIT = 8,
  parameter int unsigned ADET_BIT  = 17
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 basla_i,
  input  logic                 mod_i,
  input  logic [ADET_BIT-1:0]  piksel_sayisi_i,
  input  logic                 etkin_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  input  logic                 stal_i,
  output logic                 etkin_o,
  output logic [ADET_BIT-1:0]  veri_o,
  output logic                 hazir_o,
  output logic                 hata_o
);

  localparam int BinSayisi = 1 << PIXEL_BIT;
  localparam int PayBit    = ADET_BIT + PIXEL_BIT;
  localparam int AdimBit   = $clog2(PIXEL_BIT + 1);

  typedef enum logic [2:0] {StBos, StTemizle, StSay, StDokum, StKumul, StHesapla, StEsle} durum_e;

  durum_e                durum_q, durum_d;
  logic                  mod_q, mod_d;
  logic [ADET_BIT-1:0]   n_q, n_d;
  logic [PIXEL_BIT-1:0]  idx_q, idx_d;
  logic [ADET_BIT-1:0]   sayac_q, sayac_d;
  logic [ADET_BIT-1:0]   kum_q, kum_d;
  logic [ADET_BIT-1:0]   cdf_min_q, cdf_min_d;
  logic                  min_var_q, min_var_d;
  logic [AdimBit-1:0]    adim_q, adim_d;
  logic [ADET_BIT-1:0]   kalan_q, kalan_d;
  logic [PIXEL_BIT-1:0]  alt_q, alt_d;
  logic [PIXEL_BIT-1:0]  bolum_q, bolum_d;
  logic [ADET_BIT-1:0]   bin_q [BinSayisi];
  logic [ADET_BIT-1:0]   bin_d [BinSayisi];
  logic [PIXEL_BIT-1:0]  map_q [BinSayisi];
  logic [PIXEL_BIT-1:0]  map_d [BinSayisi];
  logic                  etkin_q, etkin_d;
  logic [ADET_BIT-1:0]   veri_q, veri_d;
  logic                  hazir_q, hazir_d;
  logic                  hata_q, hata_d;

  logic [ADET_BIT-1:0]  sayac_art, kum_top, payda, fark;
  logic [PayBit-1:0]    pay;
  logic [ADET_BIT:0]    deneme;
  logic                 buyuk_esit;
  logic [PIXEL_BIT-1:0] yeni_bolum;

  always_comb begin
    sayac_art  = sayac_q + ADET_BIT'(1);
    kum_top    = kum_q + bin_q[idx_q];
    payda      = n_q - cdf_min_q;
    fark       = bin_q[idx_q] - cdf_min_q;
    // Bins below cdf_min would underflow; force their numerator to zero.
    pay        = (bin_q[idx_q] < cdf_min_q) ? '0 : PayBit'(fark) * PayBit'(BinSayisi - 1);
    deneme     = {kalan_q, alt_q[PIXEL_BIT-1]};
    buyuk_esit = deneme >= {1'b0, payda};
    yeni_bolum = {bolum_q[PIXEL_BIT-2:0], buyuk_esit};
  end

  always_comb begin
    durum_d   = durum_q;
    mod_d     = mod_q;
    n_d       = n_q;
    idx_d     = idx_q;
    sayac_d   = sayac_q;
    kum_d     = kum_q;
    cdf_min_d = cdf_min_q;
    min_var_d = min_var_q;
    adim_d    = adim_q;
    kalan_d   = kalan_q;
    alt_d     = alt_q;
    bolum_d   = bolum_q;
    bin_d     = bin_q;
    map_d     = map_q;
    etkin_d   = 1'b0;
    veri_d    = veri_q;
    hata_d    = hata_q;
    unique case (durum_q)
      StBos: begin
        if (basla_i) begin
          if (piksel_sayisi_i == '0) begin
            hata_d = 1'b1;
          end else begin
            mod_d   = mod_i;
            n_d     = piksel_sayisi_i;
            hata_d  = 1'b0;
            idx_d   = '0;
            durum_d = StTemizle;
          end
        end
      end
      StTemizle: begin
        bin_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (&idx_q) begin
          sayac_d = '0;
          durum_d = StSay;
        end
      end
      StSay: begin
        if (etkin_i) begin
          bin_d[pixel_i] = bin_q[pixel_i] + ADET_BIT'(1);
          sayac_d        = sayac_art;
          if (sayac_art == n_q) begin
            idx_d     = '0;
            kum_d     = '0;
            min_var_d = 1'b0;
            durum_d   = mod_q ? StKumul : StDokum;
          end
        end
      end
      StDokum: begin
        etkin_d = 1'b1;
        veri_d  = bin_q[idx_q];
        idx_d   = idx_q + 1'b1;
        if (&idx_q) durum_d = StBos;
      end
      StKumul: begin
        bin_d[idx_q] = kum_top;
        kum_d        = kum_top;
        if (!min_var_q && kum_top != '0) begin
          cdf_min_d = kum_top;
          min_var_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (&idx_q) begin
          adim_d  = '0;
          durum_d = StHesapla;
        end
      end
      StHesapla: begin
        if (adim_q == '0) begin
          // Quotient fits PIXEL_BIT bits, so the high part is already below the divisor.
          kalan_d = pay[PayBit-1:PIXEL_BIT];
          alt_d   = pay[PIXEL_BIT-1:0];
          bolum_d = '0;
          adim_d  = AdimBit'(1);
        end else begin
          kalan_d = buyuk_esit ? (deneme[ADET_BIT-1:0] - payda) : deneme[ADET_BIT-1:0];
          alt_d   = alt_q << 1;
          bolum_d = yeni_bolum;
          if (adim_q == AdimBit'(PIXEL_BIT)) begin
            map_d[idx_q] = (payda == '0) ? idx_q : yeni_bolum;
            adim_d       = '0;
            idx_d        = idx_q + 1'b1;
            if (&idx_q) begin
              sayac_d = '0;
              durum_d = StEsle;
            end
          end else begin
            adim_d = adim_q + 1'b1;
          end
        end
      end
      StEsle: begin
        if (etkin_i) begin
          etkin_d = 1'b1;
          veri_d  = ADET_BIT'(map_q[pixel_i]);
          sayac_d = sayac_art;
          if (sayac_art == n_q) durum_d = StBos;
        end
      end
      default: durum_d = StBos;
    endcase
    if (etkin_i && durum_q != StSay && durum_q != StEsle) hata_d = 1'b1;
    hazir_d = (durum_d == StBos);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q   <= StBos;
      mod_q     <= 1'b0;
      n_q       <= '0;
      idx_q     <= '0;
      sayac_q   <= '0;
      kum_q     <= '0;
      cdf_min_q <= '0;
      min_var_q <= 1'b0;
      adim_q    <= '0;
      kalan_q   <= '0;
      alt_q     <= '0;
      bolum_q   <= '0;
      for (int i = 0; i < BinSayisi; i++) begin
        bin_q[i] <= '0;
        map_q[i] <= '0;
      end
      etkin_q   <= 1'b0;
      veri_q    <= '0;
      hazir_q   <= 1'b1;
      hata_q    <= 1'b0;
    end else if (!stal_i) begin
      durum_q   <= durum_d;
      mod_q     <= mod_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      sayac_q   <= sayac_d;
      kum_q     <= kum_d;
      cdf_min_q <= cdf_min_d;
      min_var_q <= min_var_d;
      adim_q    <= adim_d;
      kalan_q   <= kalan_d;
      alt_q     <= alt_d;
      bolum_q   <= bolum_d;
      bin_q     <= bin_d;
      map_q     <= map_d;
      etkin_q   <= etkin_d;
      veri_q    <= veri_d;
      hazir_q   <= hazir_d;
      hata_q    <= hata_d;
    end
  end

  assign etkin_o = etkin_q;
  assign veri_o  = veri_q;
  assign hazir_o = hazir_q;
  assign hata_o  = hata_q;

endmodule

// File: tb/tb_histogram_esitleme_birimi.sv
// Directed bench for histogram_esitleme_birimi: dump, equalisation, identity, stall, errors
// and asynchronous reset, with hand-computed expectations.
module tb_histogram_esitleme_birimi;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        basla = 1'b0;
  logic        mod = 1'b0;
  logic [16:0] n_in = '0;
  logic        etkin_i = 1'b0;
  logic [7:0]  pixel = '0;
  logic        stal = 1'b0;
  logic        etkin_o;
  logic [16:0] veri_o;
  logic        hazir_o;
  logic        hata_o;

  int vektor = 0;
  int hatali = 0;
  int beklenen [256];

  histogram_esitleme_birimi #(.PIXEL_BIT(8), .ADET_BIT(17)) dut (
    .clk_i(clk), .rstn_i(rstn), .basla_i(basla), .mod_i(mod), .piksel_sayisi_i(n_in),
    .etkin_i(etkin_i), .pixel_i(pixel), .stal_i(stal), .etkin_o(etkin_o), .veri_o(veri_o),
    .hazir_o(hazir_o), .hata_o(hata_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic m, input int n);
    basla = 1'b1; mod = m; n_in = 17'(n);
    tick();
    basla = 1'b0;
  endtask

  task automatic feed(input int p);
    pixel = 8'(p); etkin_i = 1'b1;
    tick();
    etkin_i = 1'b0;
  endtask

  task automatic clear_expected();
    for (int i = 0; i < 256; i++) beklenen[i] = 0;
  endtask

  // Collects one full dump; optionally freezes the DUT for 5 cycles at index stall_at.
  task automatic collect_dump(input int stall_at);
    int bekle;
    bekle = 0;
    while (!etkin_o && bekle < 20) begin
      tick();
      bekle++;
    end
    for (int i = 0; i < 256; i++) begin
      if (i == stall_at) begin
        stal = 1'b1;
        for (int k = 0; k < 5; k++) begin
          tick();
          vektor++;
          if (etkin_o !== 1'b1 || veri_o !== 17'(beklenen[i])) begin
            hatali++;
            $display("FAIL stall_hold[%0d]: etkin_o=%b veri_o=%0d, required 1/%0d",
                     i, etkin_o, veri_o, beklenen[i]);
          end
        end
        stal = 1'b0;
      end
      vektor++;
      if (etkin_o !== 1'b1 || veri_o !== 17'(beklenen[i])) begin
        hatali++;
        $display("FAIL dump[%0d]: etkin_o=%b veri_o=%0d, required 1/%0d",
                 i, etkin_o, veri_o, beklenen[i]);
      end
      tick();
    end
    vektor++;
    if (etkin_o !== 1'b0 || hazir_o !== 1'b1) begin
      hatali++;
      $display("FAIL dump_end: etkin_o=%b hazir_o=%b, required 0/1", etkin_o, hazir_o);
    end
  endtask

  task automatic check_esle(input int p, input int exp);
    feed(p);
    vektor++;
    if (etkin_o !== 1'b1 || veri_o !== 17'(exp)) begin
      hatali++;
      $display("FAIL esle(%0d): etkin_o=%b veri_o=%0d, required 1/%0d", p, etkin_o, veri_o, exp);
    end
  endtask

  task automatic test_reset();
    vektor++;
    if (etkin_o !== 1'b0 || veri_o !== 17'd0 || hazir_o !== 1'b1 || hata_o !== 1'b0) begin
      hatali++;
      $display("FAIL reset: etkin=%b veri=%0d hazir=%b hata=%b, required 0/0/1/0",
               etkin_o, veri_o, hazir_o, hata_o);
    end
  endtask

  task automatic test_hist();
    start(1'b0, 4);
    vektor++;
    if (hazir_o !== 1'b0) begin
      hatali++;
      $display("FAIL hist_busy: hazir_o=%b, required 0", hazir_o);
    end
    repeat (256) tick();
    feed(5); feed(5); feed(5); feed(9);
    clear_expected();
    beklenen[5] = 3; beklenen[9] = 1;
    collect_dump(-1);
  endtask

  task automatic test_stall();
    start(1'b0, 4);
    repeat (256) tick();
    feed(5); feed(5);
    pixel = 8'd5; etkin_i = 1'b1; stal = 1'b1;
    repeat (5) tick();
    stal = 1'b0; etkin_i = 1'b0;
    feed(5); feed(9);
    clear_expected();
    beklenen[5] = 3; beklenen[9] = 1;
    collect_dump(5);
    vektor++;
    if (hata_o !== 1'b0) begin
      hatali++;
      $display("FAIL stall_no_error: hata_o=%b, required 0", hata_o);
    end
  endtask

  task automatic test_esitle();
    start(1'b1, 4);
    repeat (256) tick();
    feed(10); feed(20); feed(30); feed(40);
    repeat (2600) tick();
    vektor++;
    if (hazir_o !== 1'b0) begin
      hatali++;
      $display("FAIL esle_wait: hazir_o=%b, required 0", hazir_o);
    end
    check_esle(40, 255);
    check_esle(30, 170);
    check_esle(20, 85);
    check_esle(10, 0);
    vektor++;
    if (hazir_o !== 1'b1 || hata_o !== 1'b0) begin
      hatali++;
      $display("FAIL esle_done: hazir_o=%b hata_o=%b, required 1/0", hazir_o, hata_o);
    end
  endtask

  task automatic test_identity();
    start(1'b1, 3);
    repeat (256) tick();
    feed(7); feed(7); feed(7);
    repeat (2600) tick();
    check_esle(7, 7);
    check_esle(7, 7);
    check_esle(7, 7);
  endtask

  task automatic test_async_reset();
    start(1'b1, 4);
    repeat (256) tick();
    feed(10); feed(20); feed(30); feed(40);
    repeat (300) tick();
    feed(1);
    vektor++;
    if (hata_o !== 1'b1 || hazir_o !== 1'b0) begin
      hatali++;
      $display("FAIL hesapla_error: hata_o=%b hazir_o=%b, required 1/0", hata_o, hazir_o);
    end
    #2 rstn = 1'b0;
    #1;
    vektor++;
    if (etkin_o !== 1'b0 || veri_o !== 17'd0 || hazir_o !== 1'b1 || hata_o !== 1'b0) begin
      hatali++;
      $display("FAIL async_reset: etkin=%b veri=%0d hazir=%b hata=%b, required 0/0/1/0",
               etkin_o, veri_o, hazir_o, hata_o);
    end
    #2 rstn = 1'b1;
    tick();
    start(1'b0, 4);
    repeat (256) tick();
    feed(1); feed(2); feed(2); feed(3);
    clear_expected();
    beklenen[1] = 1; beklenen[2] = 2; beklenen[3] = 1;
    collect_dump(-1);
  endtask

  task automatic test_error();
    start(1'b0, 2);
    repeat (10) tick();
    feed(3);
    vektor++;
    if (hata_o !== 1'b1) begin
      hatali++;
      $display("FAIL temizle_error: hata_o=%b, required 1", hata_o);
    end
    repeat (245) tick();
    feed(4); feed(4);
    clear_expected();
    beklenen[4] = 2;
    collect_dump(-1);
    vektor++;
    if (hata_o !== 1'b1) begin
      hatali++;
      $display("FAIL error_sticky: hata_o=%b, required 1", hata_o);
    end
    start(1'b0, 1);
    vektor++;
    if (hata_o !== 1'b0) begin
      hatali++;
      $display("FAIL error_clear: hata_o=%b, required 0", hata_o);
    end
    repeat (256) tick();
    feed(0);
    clear_expected();
    beklenen[0] = 1;
    collect_dump(-1);
    start(1'b0, 0);
    vektor++;
    if (hata_o !== 1'b1 || hazir_o !== 1'b1) begin
      hatali++;
      $display("FAIL zero_n: hata_o=%b hazir_o=%b, required 1/1", hata_o, hazir_o);
    end
  endtask

  initial begin
    #12;
    test_reset();
    rstn = 1'b1;
    tick();
    test_hist();
    test_stall();
    test_esitle();
    test_identity();
    test_async_reset();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vektor, hatali);
    $finish;
  end

endmodule
